// File: rtl/fetch_queue.sv
// Instruction fetch queue: circular FIFO of {pc, instr, fault} between fetch and decode.
// The head is shown combinationally; an empty queue presents a NOP so the decoder never sees garbage.
module fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush_i,
  input  logic                       if_v_i,
  input  logic [XLEN-1:0]            if_instr_i,
  input  logic [XLEN-1:0]            if_pc_i,
  input  logic                       if_fault_i,
  output logic                       if_ready_o,
  output logic                       dec_v_o,
  output logic [XLEN-1:0]            dec_instr_o,
  output logic [XLEN-1:0]            dec_pc_o,
  output logic                       dec_fault_o,
  input  logic                       dec_ready_i,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            fault;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;
  entry_t          head;

  assign if_ready_o = (count != CW'(DEPTH));
  assign dec_v_o    = (count != '0);
  assign push       = if_v_i & if_ready_o & ~flush_i;
  assign pop        = dec_v_o & dec_ready_i & ~flush_i;
  assign count_o    = count;

  // Head view; substitute a NOP while empty.
  always_comb begin
    head = mem[rd_ptr];
    dec_instr_o = NOP_INSTR;
    dec_pc_o    = '0;
    dec_fault_o = 1'b0;
    if (dec_v_o) begin
      dec_instr_o = head.instr;
      dec_pc_o    = head.pc;
      dec_fault_o = head.fault;
    end
  end

  // Pointers and occupancy; flush empties the queue in a single edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Entry storage is data only and carries no reset.
  always_ff @(posedge clk) begin
    if (reset_n && push) begin
      mem[wr_ptr] <= '{pc: if_pc_i, instr: if_instr_i, fault: if_fault_i};
    end
  end

  a_count_bound: assert property (@(posedge clk) disable iff (!reset_n) count <= CW'(DEPTH));
  a_no_empty_pop: assert property (@(posedge clk) disable iff (!reset_n) pop |-> (count != '0));

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random traffic against a queue-based reference model.
module tb_fetch_queue;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned XLEN  = 32;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            flush_i;
  logic            if_v_i;
  logic [XLEN-1:0] if_instr_i;
  logic [XLEN-1:0] if_pc_i;
  logic            if_fault_i;
  logic            if_ready_o;
  logic            dec_v_o;
  logic [XLEN-1:0] dec_instr_o;
  logic [XLEN-1:0] dec_pc_o;
  logic            dec_fault_o;
  logic            dec_ready_i;
  logic [2:0]      count_o;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .reset_n(reset_n), .flush_i(flush_i),
    .if_v_i(if_v_i), .if_instr_i(if_instr_i), .if_pc_i(if_pc_i), .if_fault_i(if_fault_i),
    .if_ready_o(if_ready_o), .dec_v_o(dec_v_o), .dec_instr_o(dec_instr_o),
    .dec_pc_o(dec_pc_o), .dec_fault_o(dec_fault_o), .dec_ready_i(dec_ready_i),
    .count_o(count_o)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } ent_t;

  ent_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, compare against model, advance model at posedge.
  task automatic cyc(input logic fl, input logic v, input logic [31:0] pc, input logic [31:0] ins,
                     input logic flt, input logic rdy, input logic rst);
    ent_t h;
    bit   do_push, do_pop;
    flush_i = fl; if_v_i = v; if_pc_i = pc; if_instr_i = ins;
    if_fault_i = flt; dec_ready_i = rdy; reset_n = rst;
    #1;
    if (q.size() != 0) h = q[0];
    else h = '{pc: 32'h0, instr: 32'h0000_0013, fault: 1'b0};
    chk("count",    32'(count_o),     32'(q.size()));
    chk("dec_v",    32'(dec_v_o),     32'(q.size() != 0));
    chk("if_ready", 32'(if_ready_o),  32'(q.size() != DEPTH));
    chk("dec_instr", dec_instr_o,     h.instr);
    chk("dec_pc",    dec_pc_o,        h.pc);
    chk("dec_fault", 32'(dec_fault_o), 32'(h.fault));
    do_push = v && (q.size() < DEPTH);
    do_pop  = rdy && (q.size() != 0);
    @(posedge clk);
    if (!rst || fl) q.delete();
    else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back('{pc: pc, instr: ins, fault: flt});
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] instrs [3];
    instrs[0] = 32'h0050_0093; instrs[1] = 32'h0010_8113; instrs[2] = 32'h0020_81b3;
    reset_n = 1'b0; flush_i = 1'b0; if_v_i = 1'b0; if_pc_i = '0; if_instr_i = '0;
    if_fault_i = 1'b0; dec_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    q.delete();
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_instr", dec_instr_o, 32'h0000_0013);
    chk("rst_ready", 32'(if_ready_o), 32'd1);

    // 1: three pushes, decode stalled
    for (int i = 0; i < 3; i++) cyc(0, 1, 32'(4 * i), instrs[i], 0, 0, 1);
    chk("t1_count", 32'(count_o), 32'd3);
    chk("t1_instr", dec_instr_o, 32'h0050_0093);
    chk("t1_pc", dec_pc_o, 32'h0);

    // 2: fill, drop a push while full, drain in order
    cyc(0, 1, 32'hc, 32'h0030_0213, 0, 0, 1);
    chk("t2_full_ready", 32'(if_ready_o), 32'd0);
    cyc(0, 1, 32'h10, 32'hdead_beef, 0, 1, 1);
    cyc(0, 0, 32'h0, 32'h0, 0, 1, 1);
    cyc(0, 0, 32'h0, 32'h0, 0, 1, 1);
    chk("t2_drain_pc", dec_pc_o, 32'hc);
    cyc(0, 0, 32'h0, 32'h0, 0, 1, 1);
    chk("t2_empty", 32'(dec_v_o), 32'd0);

    // 3: steady push+pop, count holds at 1 and wraps pointers
    cyc(0, 1, 32'h0, 32'h0000_0113, 0, 0, 1);
    for (int i = 1; i <= 10; i++) begin
      chk("t3_pc", dec_pc_o, 32'(4 * (i - 1)));
      chk("t3_count", 32'(count_o), 32'd1);
      cyc(0, 1, 32'(4 * i), 32'h0000_0113 + 32'(i), 0, 1, 1);
    end

    // 4: flush with concurrent push and pop at count 3
    cyc(0, 1, 32'h2c, 32'h1, 0, 0, 1);
    cyc(0, 1, 32'h30, 32'h2, 0, 0, 1);
    chk("t4_count3", 32'(count_o), 32'd3);
    cyc(1, 1, 32'h34, 32'h3, 0, 1, 1);
    chk("t4_count", 32'(count_o), 32'd0);
    chk("t4_instr", dec_instr_o, 32'h0000_0013);
    cyc(0, 0, 32'h0, 32'h0, 0, 0, 1);

    // 5: faulting entry flagged only while at the head
    cyc(0, 1, 32'hfc,  32'h11, 0, 0, 1);
    cyc(0, 1, 32'h100, 32'h22, 1, 0, 1);
    cyc(0, 1, 32'h104, 32'h33, 0, 0, 1);
    chk("t5_fault_before", 32'(dec_fault_o), 32'd0);
    cyc(0, 0, 32'h0, 32'h0, 0, 1, 1);
    chk("t5_fault_head", 32'(dec_fault_o), 32'd1);
    cyc(0, 0, 32'h0, 32'h0, 0, 1, 1);
    chk("t5_fault_after", 32'(dec_fault_o), 32'd0);

    // 6: reset mid-operation with two entries held
    cyc(0, 1, 32'h200, 32'h44, 0, 0, 1);
    chk("t6_count2", 32'(count_o), 32'd2);
    cyc(0, 1, 32'h204, 32'h55, 1, 1, 0);
    chk("t6_count", 32'(count_o), 32'd0);
    chk("t6_v", 32'(dec_v_o), 32'd0);
    chk("t6_instr", dec_instr_o, 32'h0000_0013);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 7), $urandom, $urandom,
          1'($urandom_range(0, 7) == 0), ($urandom_range(0, 9) < 6),
          ($urandom_range(0, 59) != 0));
    end
    cyc(0, 0, 32'h0, 32'h0, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
